ps2_kbmat: RTL and testbench

- Upstream feeder for the blink keyboard port: receives PS/2 keyboard frames and maintains the 64-bit pressed-key matrix (kbmat) that blink scans via A15-A8 on port $B2.
- Scan-code-to-matrix translation is an external combinational keymap. This block drives the code out and samples the returned matrix index.
- Runs on the 9.83 MHz master clock alongside blink.

---
 rtl/ps2_kbmat.sv | 211 +++++++++++++++++++++
 tb/tb_ps2_kbmat.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbmat.sv
// ps2_kbmat: PS/2 keyboard receiver that maintains the 64-bit pressed-key matrix.
// Scan codes go out to an external keymap; the returned index is applied as make or break.
module ps2_kbmat #(
    parameter int unsigned FILT    = 8,
    parameter int unsigned TIMEOUT = 19660
) (
    input  logic        mck,
    input  logic        rin_n,
    input  logic        ps2_clk,
    input  logic        ps2_dat,
    output logic [7:0]  kb_code,
    output logic        kb_ext,
    input  logic [5:0]  km_idx,
    input  logic        km_vld,
    output logic [63:0] kbmat,
    output logic        kb_evt,
    output logic        kb_err
);

    localparam int unsigned FILT_W = (FILT > 1) ? $clog2(FILT) : 1;
    localparam int unsigned TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_DATA, S_PARITY, S_STOP, S_DECODE, S_LOOKUP
    } state_e;

    state_e state_q, state_d;

    logic              clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic              filt_clk_q, filt_clk_d;
    logic [FILT_W-1:0] flt_cnt_q, flt_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [7:0]        shreg_q, shreg_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic              par_q, par_d;
    logic              ext_q, ext_d, brk_q, brk_d;
    logic [7:0]        kb_code_q, kb_code_d;
    logic              kb_ext_q, kb_ext_d;
    logic [63:0]       kbmat_q, kbmat_d;
    logic              evt_q, evt_d, err_q, err_d;

    logic strobe_c, busy_c, timeout_c, frame_ok_c;

    // Two-flop synchronisers for the asynchronous PS/2 lines (idle high).
    always_ff @(posedge mck or negedge rin_n) begin
        if (!rin_n) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_dat;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Glitch filter: the filtered clock follows only after FILT consecutive differing samples.
    always_comb begin
        filt_clk_d = filt_clk_q;
        flt_cnt_d  = '0;
        if (clk_s2_q != filt_clk_q) begin
            if (flt_cnt_q == FILT_W'(FILT - 1)) begin
                filt_clk_d = clk_s2_q;
            end else begin
                flt_cnt_d = flt_cnt_q + FILT_W'(1);
            end
        end
    end

    assign strobe_c   = filt_clk_q & ~filt_clk_d;
    assign busy_c     = (state_q == S_DATA) || (state_q == S_PARITY) || (state_q == S_STOP);
    assign timeout_c  = busy_c && !strobe_c && (to_cnt_q == TO_W'(TIMEOUT - 1));
    assign frame_ok_c = dat_s2_q & (^{shreg_q, par_q});

    // State register.
    always_ff @(posedge mck or negedge rin_n) begin
        if (!rin_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (strobe_c && !dat_s2_q) state_d = S_DATA;
            S_DATA: begin
                if (timeout_c)                              state_d = S_IDLE;
                else if (strobe_c && bit_cnt_q == 3'd7)     state_d = S_PARITY;
            end
            S_PARITY: begin
                if (timeout_c)     state_d = S_IDLE;
                else if (strobe_c) state_d = S_STOP;
            end
            S_STOP: begin
                if (timeout_c)     state_d = S_IDLE;
                else if (strobe_c) state_d = frame_ok_c ? S_DECODE : S_IDLE;
            end
            S_DECODE: begin
                case (shreg_q)
                    8'hE0, 8'hF0, 8'hE1, 8'hAA: state_d = S_IDLE;
                    default:                    state_d = S_LOOKUP;
                endcase
            end
            S_LOOKUP: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath/output next values: shifting, flags, matrix update, pulses, timeout count.
    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        par_d     = par_q;
        ext_d     = ext_q;
        brk_d     = brk_q;
        kb_code_d = kb_code_q;
        kb_ext_d  = kb_ext_q;
        kbmat_d   = kbmat_q;
        evt_d     = 1'b0;
        err_d     = 1'b0;
        to_cnt_d  = '0;
        if (busy_c && !strobe_c) to_cnt_d = to_cnt_q + TO_W'(1);

        unique case (state_q)
            S_IDLE: if (strobe_c && !dat_s2_q) bit_cnt_d = 3'd0;
            S_DATA, S_PARITY, S_STOP: begin
                if (timeout_c) begin
                    err_d = 1'b1;
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end else if (strobe_c) begin
                    if (state_q == S_DATA) begin
                        shreg_d   = {dat_s2_q, shreg_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end else if (state_q == S_PARITY) begin
                        par_d = dat_s2_q;
                    end else if (!frame_ok_c) begin
                        err_d = 1'b1;
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end
                end
            end
            S_DECODE: begin
                case (shreg_q)
                    8'hE0: ext_d = 1'b1;
                    8'hF0: brk_d = 1'b1;
                    8'hE1, 8'hAA: begin
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end
                    default: begin
                        kb_code_d = shreg_q;
                        kb_ext_d  = ext_q;
                    end
                endcase
            end
            S_LOOKUP: begin
                if (km_vld && (kbmat_q[km_idx] != ~brk_q)) begin
                    kbmat_d[km_idx] = ~brk_q;
                    evt_d           = 1'b1;
                end
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge mck or negedge rin_n) begin
        if (!rin_n) begin
            filt_clk_q <= 1'b1;
            flt_cnt_q  <= '0;
            to_cnt_q   <= '0;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            par_q      <= 1'b0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            kb_code_q  <= '0;
            kb_ext_q   <= 1'b0;
            kbmat_q    <= '0;
            evt_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            filt_clk_q <= filt_clk_d;
            flt_cnt_q  <= flt_cnt_d;
            to_cnt_q   <= to_cnt_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            par_q      <= par_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            kb_code_q  <= kb_code_d;
            kb_ext_q   <= kb_ext_d;
            kbmat_q    <= kbmat_d;
            evt_q      <= evt_d;
            err_q      <= err_d;
        end
    end

    assign kb_code = kb_code_q;
    assign kb_ext  = kb_ext_q;
    assign kbmat   = kbmat_q;
    assign kb_evt  = evt_q;
    assign kb_err  = err_q;

endmodule

// File: tb/tb_ps2_kbmat.sv
// Bench for ps2_kbmat: directed PS/2 frames, expected events queued, monitor compares.
module tb_ps2_kbmat;

    localparam int unsigned TIMEOUT = 19660;

    logic        mck = 1'b0;
    logic        rin_n;
    logic        ps2_clk, ps2_dat;
    logic [7:0]  kb_code;
    logic        kb_ext;
    logic [5:0]  km_idx;
    logic        km_vld;
    logic [63:0] kbmat;
    logic        kb_evt, kb_err;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        is_err;
        logic [63:0] mat;
        logic [7:0]  code;
        logic        ext;
    } exp_t;

    exp_t exp_q[$];

    ps2_kbmat #(.FILT(8), .TIMEOUT(TIMEOUT)) dut (
        .mck(mck), .rin_n(rin_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .kb_code(kb_code), .kb_ext(kb_ext), .km_idx(km_idx), .km_vld(km_vld),
        .kbmat(kbmat), .kb_evt(kb_evt), .kb_err(kb_err)
    );

    always #5 mck = ~mck;

    // External keymap stand-in.
    always_comb begin
        km_vld = 1'b0;
        km_idx = 6'd0;
        case ({kb_ext, kb_code})
            9'h01C: begin km_vld = 1'b1; km_idx = 6'd9;  end
            9'h175: begin km_vld = 1'b1; km_idx = 6'd62; end
            9'h075: begin km_vld = 1'b1; km_idx = 6'd20; end
            9'h01B: begin km_vld = 1'b1; km_idx = 6'd5;  end
            default: ;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: pops one expectation per kb_evt / kb_err pulse.
    always @(negedge mck) begin
        exp_t e;
        if (rin_n) begin
            if (kb_evt && kb_err) chk("evt_err_overlap", 64'(1), 64'(0));
            if (kb_evt || kb_err) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", {62'd0, kb_err, kb_evt}, 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_kind", 64'(kb_err), 64'(e.is_err));
                    chk("kbmat", kbmat, e.mat);
                    if (!e.is_err) begin
                        chk("kb_code", 64'(kb_code), 64'(e.code));
                        chk("kb_ext", 64'(kb_ext), 64'(e.ext));
                    end
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge mck);
    endtask

    task automatic send_bit(input logic b);
        ps2_dat = b;
        wait_cyc(10);
        ps2_clk = 1'b0;
        wait_cyc(20);
        ps2_clk = 1'b1;
        wait_cyc(10);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par = 1'b0,
                              input logic bad_stop = 1'b0);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad_par);
        send_bit(~bad_stop);
        ps2_dat = 1'b1;
        wait_cyc(10);
    endtask

    task automatic expect_evt(input logic [63:0] mat, input logic [7:0] code, input logic ext);
        exp_q.push_back('{is_err: 1'b0, mat: mat, code: code, ext: ext});
    endtask

    task automatic expect_err(input logic [63:0] mat);
        exp_q.push_back('{is_err: 1'b1, mat: mat, code: 8'h00, ext: 1'b0});
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge mck);
        wait_cyc(20);
        chk(name, 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rin_n   = 1'b0;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        wait_cyc(5);
        chk("rst_kbmat", kbmat, 64'd0);
        chk("rst_code", 64'(kb_code), 64'(0));
        chk("rst_ext", 64'(kb_ext), 64'(0));
        chk("rst_evt", 64'(kb_evt), 64'(0));
        chk("rst_err", 64'(kb_err), 64'(0));
        rin_n = 1'b1;
        wait_cyc(20);

        // Make, break, make, typematic repeat.
        expect_evt(64'h0000_0000_0000_0200, 8'h1C, 1'b0);
        send_frame(8'h1C);
        drain("make_1c", 100);
        send_frame(8'hF0);
        expect_evt(64'h0000_0000_0000_0000, 8'h1C, 1'b0);
        send_frame(8'h1C);
        drain("break_1c", 100);
        expect_evt(64'h0000_0000_0000_0200, 8'h1C, 1'b0);
        send_frame(8'h1C);
        send_frame(8'h1C);
        drain("typematic_1c", 100);

        // Extended prefix, then the same code without it.
        send_frame(8'hE0);
        expect_evt(64'h4000_0000_0000_0200, 8'h75, 1'b1);
        send_frame(8'h75);
        drain("ext_75", 100);
        expect_evt(64'h4000_0000_0010_0200, 8'h75, 1'b0);
        send_frame(8'h75);
        drain("plain_75", 100);

        // Unmapped code leaves the matrix alone.
        send_frame(8'h15);
        drain("unmapped_15", 100);

        // Parity error, then recovery with a break.
        expect_err(64'h4000_0000_0010_0200);
        send_frame(8'h1C, 1'b1, 1'b0);
        drain("bad_parity", 100);
        send_frame(8'hF0);
        expect_evt(64'h4000_0000_0010_0000, 8'h1C, 1'b0);
        send_frame(8'h1C);
        drain("after_parity", 100);

        // Stop-bit error, then recovery.
        expect_err(64'h4000_0000_0010_0000);
        send_frame(8'h1C, 1'b0, 1'b1);
        drain("bad_stop", 100);
        expect_evt(64'h4000_0000_0010_0200, 8'h1C, 1'b0);
        send_frame(8'h1C);
        drain("after_stop", 100);

        // An error after F0 must clear the break flag.
        send_frame(8'hF0);
        expect_err(64'h4000_0000_0010_0200);
        send_frame(8'h1B, 1'b1, 1'b0);
        drain("err_after_f0", 100);
        expect_evt(64'h4000_0000_0010_0220, 8'h1B, 1'b0);
        send_frame(8'h1B);
        drain("make_1b", 100);

        // Release 9, then a truncated frame that must time out once.
        send_frame(8'hF0);
        expect_evt(64'h4000_0000_0010_0020, 8'h1C, 1'b0);
        send_frame(8'h1C);
        drain("break_1c_2", 100);
        expect_err(64'h4000_0000_0010_0020);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        ps2_dat = 1'b1;
        drain("timeout", TIMEOUT + 500);
        wait_cyc(200);
        expect_evt(64'h4000_0000_0010_0220, 8'h1C, 1'b0);
        send_frame(8'h1C);
        drain("after_timeout", 100);

        // Short low glitches on ps2_clk with dat low must not start a frame.
        ps2_dat = 1'b0;
        for (int g = 0; g < 5; g++) begin
            ps2_clk = 1'b0;
            wait_cyc(3);
            ps2_clk = 1'b1;
            wait_cyc(15);
        end
        ps2_dat = 1'b1;
        wait_cyc(20);
        send_frame(8'hF0);
        expect_evt(64'h4000_0000_0010_0200, 8'h1B, 1'b0);
        send_frame(8'h1B);
        drain("after_glitch", 100);

        // Asynchronous reset in the middle of a frame.
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        #2;
        rin_n = 1'b0;
        #1;
        chk("arst_kbmat", kbmat, 64'd0);
        chk("arst_code", 64'(kb_code), 64'(0));
        chk("arst_ext", 64'(kb_ext), 64'(0));
        chk("arst_evt", 64'(kb_evt), 64'(0));
        chk("arst_err", 64'(kb_err), 64'(0));
        @(negedge mck);
        rin_n = 1'b1;
        ps2_dat = 1'b1;
        wait_cyc(50);
        expect_evt(64'h0000_0000_0000_0200, 8'h1C, 1'b0);
        send_frame(8'h1C);
        drain("after_reset", 100);

        wait_cyc(50);
        chk("final_queue", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
